// File: rtl/id_stage_reg.sv
// ID/EX pipeline register for the five-stage ARM core.
// It captures the decode control word and the decoded operands, then presents them to execute one cycle later.
// Supports hazard freeze, branch flush (bubble insertion) and a saturating bubble counter.
module id_stage_reg #(
  parameter int DATA_WIDTH       = 32,
  parameter int BUBBLE_CNT_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        freeze,
  input  logic                        valid_in,
  input  logic [3:0]                  execute_command_in,
  input  logic                        mem_read_in,
  input  logic                        mem_write_in,
  input  logic                        wb_enable_in,
  input  logic                        branch_taken_in,
  input  logic                        status_write_enable_in,
  input  logic                        immediate_in,
  input  logic                        ignore_hazard_in,
  input  logic [DATA_WIDTH-1:0]       pc_in,
  input  logic [DATA_WIDTH-1:0]       val_rn_in,
  input  logic [DATA_WIDTH-1:0]       val_rm_in,
  input  logic [11:0]                 shift_operand_in,
  input  logic [23:0]                 signed_imm_24_in,
  input  logic [3:0]                  dest_in,
  input  logic [3:0]                  src1_in,
  input  logic [3:0]                  src2_in,
  input  logic                        carry_in,
  output logic [3:0]                  execute_command_out,
  output logic                        mem_read_out,
  output logic                        mem_write_out,
  output logic                        wb_enable_out,
  output logic                        branch_taken_out,
  output logic                        status_write_enable_out,
  output logic                        immediate_out,
  output logic                        ignore_hazard_out,
  output logic [DATA_WIDTH-1:0]       pc_out,
  output logic [DATA_WIDTH-1:0]       val_rn_out,
  output logic [DATA_WIDTH-1:0]       val_rm_out,
  output logic [11:0]                 shift_operand_out,
  output logic [23:0]                 signed_imm_24_out,
  output logic [3:0]                  dest_out,
  output logic [3:0]                  src1_out,
  output logic [3:0]                  src2_out,
  output logic                        carry_out,
  output logic                        valid_out,
  output logic [BUBBLE_CNT_WIDTH-1:0] bubble_count
);

  // The control word is kept packed so a bubble is simply an all-zero vector.
  localparam int CTRL_W = 11;

  logic [CTRL_W-1:0]           ctrl_in;
  logic [CTRL_W-1:0]           ctrl_q, ctrl_d;
  logic [DATA_WIDTH-1:0]       pc_q, pc_d;
  logic [DATA_WIDTH-1:0]       val_rn_q, val_rn_d;
  logic [DATA_WIDTH-1:0]       val_rm_q, val_rm_d;
  logic [11:0]                 shift_q, shift_d;
  logic [23:0]                 simm_q, simm_d;
  logic [3:0]                  dest_q, dest_d;
  logic [3:0]                  src1_q, src1_d;
  logic [3:0]                  src2_q, src2_d;
  logic                        carry_q, carry_d;
  logic                        valid_q, valid_d;
  logic [BUBBLE_CNT_WIDTH-1:0] bubble_q, bubble_d;
  logic                        bubble_event;

  assign ctrl_in = {execute_command_in, mem_read_in, mem_write_in, wb_enable_in,
                    branch_taken_in, status_write_enable_in, immediate_in,
                    ignore_hazard_in};

  // A bubble enters execute on a flush, or on a normal load of a non-instruction.
  assign bubble_event = flush | (~freeze & ~valid_in);

  // Next-state selection: flush beats freeze, and freeze beats a normal load.
  always_comb begin
    ctrl_d   = ctrl_q;
    pc_d     = pc_q;
    val_rn_d = val_rn_q;
    val_rm_d = val_rm_q;
    shift_d  = shift_q;
    simm_d   = simm_q;
    dest_d   = dest_q;
    src1_d   = src1_q;
    src2_d   = src2_q;
    carry_d  = carry_q;
    valid_d  = valid_q;
    if (flush) begin
      ctrl_d   = '0;
      pc_d     = '0;
      val_rn_d = '0;
      val_rm_d = '0;
      shift_d  = '0;
      simm_d   = '0;
      dest_d   = '0;
      src1_d   = '0;
      src2_d   = '0;
      carry_d  = 1'b0;
      valid_d  = 1'b0;
    end else if (!freeze) begin
      // A non-instruction must not carry side effects, so its control word is zeroed.
      ctrl_d   = valid_in ? ctrl_in : '0;
      pc_d     = pc_in;
      val_rn_d = val_rn_in;
      val_rm_d = val_rm_in;
      shift_d  = shift_operand_in;
      simm_d   = signed_imm_24_in;
      dest_d   = dest_in;
      src1_d   = src1_in;
      src2_d   = src2_in;
      carry_d  = carry_in;
      valid_d  = valid_in;
    end
  end

  // Saturating bubble counter: it stops at all-ones rather than wrapping.
  always_comb begin
    bubble_d = bubble_q;
    if (bubble_event && (bubble_q != {BUBBLE_CNT_WIDTH{1'b1}})) begin
      bubble_d = bubble_q + 1'b1;
    end
  end

  // State registers with synchronous reset, which overrides flush and freeze.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q   <= '0;
      pc_q     <= '0;
      val_rn_q <= '0;
      val_rm_q <= '0;
      shift_q  <= '0;
      simm_q   <= '0;
      dest_q   <= '0;
      src1_q   <= '0;
      src2_q   <= '0;
      carry_q  <= 1'b0;
      valid_q  <= 1'b0;
      bubble_q <= '0;
    end else begin
      ctrl_q   <= ctrl_d;
      pc_q     <= pc_d;
      val_rn_q <= val_rn_d;
      val_rm_q <= val_rm_d;
      shift_q  <= shift_d;
      simm_q   <= simm_d;
      dest_q   <= dest_d;
      src1_q   <= src1_d;
      src2_q   <= src2_d;
      carry_q  <= carry_d;
      valid_q  <= valid_d;
      bubble_q <= bubble_d;
    end
  end

  assign {execute_command_out, mem_read_out, mem_write_out, wb_enable_out,
          branch_taken_out, status_write_enable_out, immediate_out,
          ignore_hazard_out} = ctrl_q;
  assign pc_out            = pc_q;
  assign val_rn_out        = val_rn_q;
  assign val_rm_out        = val_rm_q;
  assign shift_operand_out = shift_q;
  assign signed_imm_24_out = simm_q;
  assign dest_out          = dest_q;
  assign src1_out          = src1_q;
  assign src2_out          = src2_q;
  assign carry_out         = carry_q;
  assign valid_out         = valid_q;
  assign bubble_count      = bubble_q;

endmodule

// File: tb/tb_id_stage_reg.sv
// Scoreboard bench for id_stage_reg.
// Stimulus pushes expected register contents and a separate monitor compares them after each edge.
// A second instance with a 4-bit counter exercises saturation on the same stimulus.
module tb_id_stage_reg;

  typedef struct packed {
    logic [3:0]  cmd;
    logic        mr, mw, wb, br, sw, imm, ih;
    logic [31:0] pc, rn, rm;
    logic [11:0] sh;
    logic [23:0] simm;
    logic [3:0]  dest, s1, s2;
    logic        c;
    logic        v;
  } word_t;

  typedef struct packed {
    word_t       w;
    logic [15:0] cnt;
    logic [3:0]  cnt_s;
  } exp_t;

  logic clk = 1'b0;
  logic rst, flush, freeze;
  word_t in_w;
  word_t out_w, s_out_w;
  logic [15:0] bubble_count;
  logic [3:0]  s_bubble_count;

  // outputs of the wide-counter instance
  logic [3:0]  execute_command_out, dest_out, src1_out, src2_out;
  logic        mem_read_out, mem_write_out, wb_enable_out, branch_taken_out;
  logic        status_write_enable_out, immediate_out, ignore_hazard_out, carry_out, valid_out;
  logic [31:0] pc_out, val_rn_out, val_rm_out;
  logic [11:0] shift_operand_out;
  logic [23:0] signed_imm_24_out;
  // outputs of the 4-bit-counter instance
  logic [3:0]  s_execute_command_out, s_dest_out, s_src1_out, s_src2_out;
  logic        s_mem_read_out, s_mem_write_out, s_wb_enable_out, s_branch_taken_out;
  logic        s_status_write_enable_out, s_immediate_out, s_ignore_hazard_out, s_carry_out, s_valid_out;
  logic [31:0] s_pc_out, s_val_rn_out, s_val_rm_out;
  logic [11:0] s_shift_operand_out;
  logic [23:0] s_signed_imm_24_out;

  always #5 clk = ~clk;

  id_stage_reg #(.DATA_WIDTH(32), .BUBBLE_CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .flush(flush), .freeze(freeze), .valid_in(in_w.v),
    .execute_command_in(in_w.cmd), .mem_read_in(in_w.mr), .mem_write_in(in_w.mw),
    .wb_enable_in(in_w.wb), .branch_taken_in(in_w.br), .status_write_enable_in(in_w.sw),
    .immediate_in(in_w.imm), .ignore_hazard_in(in_w.ih), .pc_in(in_w.pc),
    .val_rn_in(in_w.rn), .val_rm_in(in_w.rm), .shift_operand_in(in_w.sh),
    .signed_imm_24_in(in_w.simm), .dest_in(in_w.dest), .src1_in(in_w.s1),
    .src2_in(in_w.s2), .carry_in(in_w.c),
    .execute_command_out(execute_command_out), .mem_read_out(mem_read_out),
    .mem_write_out(mem_write_out), .wb_enable_out(wb_enable_out),
    .branch_taken_out(branch_taken_out), .status_write_enable_out(status_write_enable_out),
    .immediate_out(immediate_out), .ignore_hazard_out(ignore_hazard_out),
    .pc_out(pc_out), .val_rn_out(val_rn_out), .val_rm_out(val_rm_out),
    .shift_operand_out(shift_operand_out), .signed_imm_24_out(signed_imm_24_out),
    .dest_out(dest_out), .src1_out(src1_out), .src2_out(src2_out),
    .carry_out(carry_out), .valid_out(valid_out), .bubble_count(bubble_count)
  );

  id_stage_reg #(.DATA_WIDTH(32), .BUBBLE_CNT_WIDTH(4)) dut_sat (
    .clk(clk), .rst(rst), .flush(flush), .freeze(freeze), .valid_in(in_w.v),
    .execute_command_in(in_w.cmd), .mem_read_in(in_w.mr), .mem_write_in(in_w.mw),
    .wb_enable_in(in_w.wb), .branch_taken_in(in_w.br), .status_write_enable_in(in_w.sw),
    .immediate_in(in_w.imm), .ignore_hazard_in(in_w.ih), .pc_in(in_w.pc),
    .val_rn_in(in_w.rn), .val_rm_in(in_w.rm), .shift_operand_in(in_w.sh),
    .signed_imm_24_in(in_w.simm), .dest_in(in_w.dest), .src1_in(in_w.s1),
    .src2_in(in_w.s2), .carry_in(in_w.c),
    .execute_command_out(s_execute_command_out), .mem_read_out(s_mem_read_out),
    .mem_write_out(s_mem_write_out), .wb_enable_out(s_wb_enable_out),
    .branch_taken_out(s_branch_taken_out), .status_write_enable_out(s_status_write_enable_out),
    .immediate_out(s_immediate_out), .ignore_hazard_out(s_ignore_hazard_out),
    .pc_out(s_pc_out), .val_rn_out(s_val_rn_out), .val_rm_out(s_val_rm_out),
    .shift_operand_out(s_shift_operand_out), .signed_imm_24_out(s_signed_imm_24_out),
    .dest_out(s_dest_out), .src1_out(s_src1_out), .src2_out(s_src2_out),
    .carry_out(s_carry_out), .valid_out(s_valid_out), .bubble_count(s_bubble_count)
  );

  assign out_w = {execute_command_out, mem_read_out, mem_write_out, wb_enable_out,
                  branch_taken_out, status_write_enable_out, immediate_out, ignore_hazard_out,
                  pc_out, val_rn_out, val_rm_out, shift_operand_out, signed_imm_24_out,
                  dest_out, src1_out, src2_out, carry_out, valid_out};
  assign s_out_w = {s_execute_command_out, s_mem_read_out, s_mem_write_out, s_wb_enable_out,
                    s_branch_taken_out, s_status_write_enable_out, s_immediate_out,
                    s_ignore_hazard_out, s_pc_out, s_val_rn_out, s_val_rm_out,
                    s_shift_operand_out, s_signed_imm_24_out, s_dest_out, s_src1_out,
                    s_src2_out, s_carry_out, s_valid_out};

  int checks = 0;
  int failures = 0;
  exp_t exp_q[$];

  // reference state: what execute should see, and how many bubbles were inserted
  word_t m_w;
  int    m_cnt;
  int    m_cnt_s;

  function automatic logic [10:0] ctrl_of(word_t w);
    return {w.cmd, w.mr, w.mw, w.wb, w.br, w.sw, w.imm, w.ih};
  endfunction

  function automatic logic [144:0] data_of(word_t w);
    return {w.pc, w.rn, w.rm, w.sh, w.simm, w.dest, w.s1, w.s2, w.c};
  endfunction

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
    end
  endtask

  function automatic word_t rand_word();
    word_t w;
    w.cmd = 4'($urandom); w.mr = 1'($urandom); w.mw = 1'($urandom);
    w.wb = 1'($urandom); w.br = 1'($urandom); w.sw = 1'($urandom);
    w.imm = 1'($urandom); w.ih = 1'($urandom);
    w.pc = $urandom; w.rn = $urandom; w.rm = $urandom;
    w.sh = 12'($urandom); w.simm = 24'($urandom);
    w.dest = 4'($urandom); w.s1 = 4'($urandom); w.s2 = 4'($urandom);
    w.c = 1'($urandom); w.v = 1'b1;
    return w;
  endfunction

  // Drive one cycle of stimulus and queue what execute must hold after the coming edge.
  task automatic step(input word_t w, input logic r, input logic fl, input logic fz);
    exp_t e;
    @(negedge clk);
    in_w = w; rst = r; flush = fl; freeze = fz;
    if (r) begin
      m_w = '0; m_cnt = 0; m_cnt_s = 0;
    end else begin
      if (fl || (!fz && !w.v)) begin
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt_s < 15) m_cnt_s++;
      end
      if (fl) begin
        m_w = '0;
      end else if (!fz) begin
        m_w = w;
        if (!w.v) begin
          m_w.cmd = '0; m_w.mr = 0; m_w.mw = 0; m_w.wb = 0;
          m_w.br = 0; m_w.sw = 0; m_w.imm = 0; m_w.ih = 0;
        end
      end
    end
    e.w = m_w;
    e.cnt = 16'(m_cnt);
    e.cnt_s = 4'(m_cnt_s);
    exp_q.push_back(e);
    $display("step t=%0t rst=%0b flush=%0b freeze=%0b valid_in=%0b pc_in=%h rn_in=%h exp_valid=%0b exp_cnt=%0d",
             $time, r, fl, fz, w.v, w.pc, w.rn, m_w.v, m_cnt);
  endtask

  // Monitor: compares the registered outputs against the oldest queued expectation.
  exp_t mon_e;
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("ctrl", 160'(ctrl_of(out_w)), 160'(ctrl_of(mon_e.w)));
      chk("data", 160'(data_of(out_w)), 160'(data_of(mon_e.w)));
      chk("valid_out", 160'(out_w.v), 160'(mon_e.w.v));
      chk("bubble_count", 160'(bubble_count), 160'(mon_e.cnt));
      chk("sat_outputs", 160'(s_out_w), 160'(mon_e.w));
      chk("sat_bubble_count", 160'(s_bubble_count), 160'(mon_e.cnt_s));
    end
  end

  initial begin
    word_t w;
    in_w = '0; rst = 1'b1; flush = 1'b0; freeze = 1'b0;
    m_w = '0; m_cnt = 0; m_cnt_s = 0;

    // reset then load
    step('0, 1, 0, 0);
    step('0, 1, 0, 0);
    w = '0; w.pc = 32'h8; w.cmd = 4'b0010; w.wb = 1; w.dest = 4'd3; w.v = 1;
    step(w, 0, 0, 0);

    // freeze hold: stalled value is kept and the new input is taken afterwards
    w = rand_word(); w.rn = 32'h12345678;
    step(w, 0, 0, 0);
    w.rn = 32'hDEADBEEF;
    for (int i = 0; i < 3; i++) step(w, 0, 0, 1);
    step(w, 0, 0, 0);

    // flush after a store
    w = '0; w.mw = 1; w.v = 1;
    step(w, 0, 0, 0);
    step(rand_word(), 0, 1, 0);

    // flush together with freeze while a write-back is in execute
    w = rand_word(); w.wb = 1;
    step(w, 0, 0, 0);
    step(rand_word(), 0, 1, 1);

    // invalid instruction with side-effect bits set
    w = rand_word(); w.v = 0; w.wb = 1; w.br = 1;
    step(w, 0, 0, 0);

    // reset in the middle of a freeze
    step(rand_word(), 0, 0, 0);
    step(rand_word(), 0, 0, 1);
    step(rand_word(), 1, 0, 1);
    step(rand_word(), 0, 0, 0);

    // long flush saturates the narrow counter, then reset clears it
    for (int i = 0; i < 20; i++) step(rand_word(), 0, 1, 0);
    step(rand_word(), 0, 0, 1);
    step(rand_word(), 1, 0, 0);
    step(rand_word(), 0, 0, 0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      w = rand_word();
      w.v = ($urandom_range(0, 99) < 75);
      step(w, ($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 10),
           ($urandom_range(0, 99) < 25));
    end

    step(rand_word(), 0, 0, 0);
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
